// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for C = A x B: walks the M x K x N problem in tile steps
// (k innermost, then col, then row), issues one engine command per step over
// a valid/ready channel, bounds in-flight output tiles and reports done/error.
module matmul_tile_scheduler #(
    parameter int unsigned DIM_W     = 12,
    parameter int unsigned TILE_M    = 16,
    parameter int unsigned TILE_N    = 16,
    parameter int unsigned TILE_K    = 16,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic             matrix_A_ready,
    input  logic             matrix_B_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [DIM_W-1:0] cmd_row,
    output logic [DIM_W-1:0] cmd_col,
    output logic [DIM_W-1:0] cmd_k,
    output logic [DIM_W-1:0] cmd_rows,
    output logic [DIM_W-1:0] cmd_cols,
    output logic [DIM_W-1:0] cmd_depth,
    output logic             cmd_first_k,
    output logic             cmd_last_k,
    input  logic             tile_done,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned EW = DIM_W + 1;
    localparam int unsigned OW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [DIM_W-1:0] dim_m;
    logic [DIM_W-1:0] dim_k;
    logic [DIM_W-1:0] dim_n;
    logic [OW-1:0]    outst;

    logic [EW-1:0]    k_sum;
    logic [EW-1:0]    col_sum;
    logic [EW-1:0]    row_sum;
    logic             last_col;
    logic             last_row;
    logic             accept;
    logic             final_cmd;
    logic [DIM_W-1:0] nxt_row;
    logic [DIM_W-1:0] nxt_col;
    logic [DIM_W-1:0] nxt_k;
    logic [DIM_W-1:0] nxt_rows;
    logic [DIM_W-1:0] nxt_cols;
    logic [DIM_W-1:0] nxt_depth;
    logic             nxt_first;
    logic             nxt_last;
    logic             out_inc;
    logic             out_dec;
    logic [OW-1:0]    out_nxt;
    logic             issue_ok;
    logic             ops_ok;
    logic             fault;

    // Clipped tile extent: min(tile, dim - idx), evaluated one bit wider
    function automatic logic [DIM_W-1:0] clip_ext(input logic [DIM_W-1:0] dim,
                                                  input logic [DIM_W-1:0] idx,
                                                  input int unsigned      tile);
        logic [EW-1:0] rem;
        rem = {1'b0, dim} - {1'b0, idx};
        if (rem > EW'(tile)) begin
            return DIM_W'(tile);
        end
        return rem[DIM_W-1:0];
    endfunction

    // Next command indices/fields, outstanding-count update and throttle decision
    always_comb begin
        k_sum     = {1'b0, cmd_k}   + EW'(TILE_K);
        col_sum   = {1'b0, cmd_col} + EW'(TILE_N);
        row_sum   = {1'b0, cmd_row} + EW'(TILE_M);
        last_col  = (col_sum >= {1'b0, dim_n});
        last_row  = (row_sum >= {1'b0, dim_m});
        accept    = cmd_valid && cmd_ready;
        final_cmd = accept && cmd_last_k && last_col && last_row;

        nxt_row = cmd_row;
        nxt_col = cmd_col;
        nxt_k   = cmd_k;
        if (accept) begin
            if (cmd_last_k) begin
                nxt_k = '0;
                if (last_col) begin
                    nxt_col = '0;
                    nxt_row = row_sum[DIM_W-1:0];
                end else begin
                    nxt_col = col_sum[DIM_W-1:0];
                end
            end else begin
                nxt_k = k_sum[DIM_W-1:0];
            end
        end

        nxt_rows  = clip_ext(dim_m, nxt_row, TILE_M);
        nxt_cols  = clip_ext(dim_n, nxt_col, TILE_N);
        nxt_depth = clip_ext(dim_k, nxt_k, TILE_K);
        nxt_first = (nxt_k == '0);
        nxt_last  = (({1'b0, nxt_k} + EW'(TILE_K)) >= {1'b0, dim_k});

        // A completion with nothing outstanding is a fault, never an underflow
        out_inc = accept && cmd_last_k;
        out_dec = tile_done && (outst != '0);
        fault   = tile_done && (outst == '0);
        case ({out_inc, out_dec})
            2'b10:   out_nxt = outst + OW'(1);
            2'b01:   out_nxt = outst - OW'(1);
            default: out_nxt = outst;
        endcase

        // A new output tile may only open while below the in-flight limit
        issue_ok = !(nxt_first && (out_nxt >= OW'(MAX_OUTST)));
        ops_ok   = matrix_A_ready && matrix_B_ready;
    end

    // Control FSM with registered command channel and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dim_m       <= '0;
            dim_k       <= '0;
            dim_n       <= '0;
            outst       <= '0;
            cmd_valid   <= 1'b0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            cmd_k       <= '0;
            cmd_rows    <= '0;
            cmd_cols    <= '0;
            cmd_depth   <= '0;
            cmd_first_k <= 1'b0;
            cmd_last_k  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        dim_m   <= cfg_m;
                        dim_k   <= cfg_k;
                        dim_n   <= cfg_n;
                        cmd_row <= '0;
                        cmd_col <= '0;
                        cmd_k   <= '0;
                        outst   <= '0;
                        if ((cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0)) begin
                            state <= S_ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_WAIT_OPS;
                            error <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_WAIT_OPS: begin
                    if (fault) begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (ops_ok) begin
                        state       <= S_ISSUE;
                        outst       <= out_nxt;
                        cmd_rows    <= nxt_rows;
                        cmd_cols    <= nxt_cols;
                        cmd_depth   <= nxt_depth;
                        cmd_first_k <= nxt_first;
                        cmd_last_k  <= nxt_last;
                        cmd_valid   <= issue_ok;
                    end
                end

                S_ISSUE: begin
                    if (!ops_ok || fault) begin
                        state     <= S_ERR;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
                    end else begin
                        outst <= out_nxt;
                        if (final_cmd) begin
                            state     <= S_DRAIN;
                            cmd_valid <= 1'b0;
                        end else if (!(cmd_valid && !cmd_ready)) begin
                            cmd_row     <= nxt_row;
                            cmd_col     <= nxt_col;
                            cmd_k       <= nxt_k;
                            cmd_rows    <= nxt_rows;
                            cmd_cols    <= nxt_cols;
                            cmd_depth   <= nxt_depth;
                            cmd_first_k <= nxt_first;
                            cmd_last_k  <= nxt_last;
                            cmd_valid   <= issue_ok;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!ops_ok || fault) begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        outst <= out_nxt;
                        if (outst == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with a simple engine model.
module tb_matmul_tile_scheduler;

    localparam int unsigned DIM_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_m, cfg_k, cfg_n;
    logic             matrix_A_ready, matrix_B_ready;
    logic             cmd_valid, cmd_ready;
    logic [DIM_W-1:0] cmd_row, cmd_col, cmd_k, cmd_rows, cmd_cols, cmd_depth;
    logic             cmd_first_k, cmd_last_k;
    logic             tile_done;
    logic             busy, done, error;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0;
    int n;
    logic [127:0] cmdq[$];
    logic [127:0] exp2[6];
    logic         auto_done = 1'b0;
    logic         rnd_ready = 1'b0;
    logic         stab_en = 1'b0;
    logic         man_done = 1'b0;
    logic [2:0]   pipe = 3'b000;
    logic         prev_hold = 1'b0;
    logic [127:0] prev_fields = '0;
    logic [127:0] cur_fields;

    always #5 clk = ~clk;

    matmul_tile_scheduler #(
        .DIM_W(12), .TILE_M(16), .TILE_N(16), .TILE_K(16), .MAX_OUTST(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .matrix_A_ready(matrix_A_ready), .matrix_B_ready(matrix_B_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_k(cmd_k),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_depth(cmd_depth),
        .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k),
        .tile_done(tile_done), .busy(busy), .done(done), .error(error)
    );

    function automatic logic [127:0] pk(input int r, input int c, input int k,
                                        input int rs, input int cs, input int d,
                                        input logic f, input logic l);
        return {54'd0, 12'(r), 12'(c), 12'(k), 12'(rs), 12'(cs), 12'(d), f, l};
    endfunction

    assign cur_fields = pk(int'(cmd_row), int'(cmd_col), int'(cmd_k), int'(cmd_rows),
                           int'(cmd_cols), int'(cmd_depth), cmd_first_k, cmd_last_k);
    assign tile_done  = man_done | pipe[2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine model: log accepted commands, return tile_done 3 cycles after a last_k accept
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (cmd_valid && cmd_ready) cmdq.push_back(cur_fields);
        pipe <= {pipe[1:0], auto_done && cmd_valid && cmd_ready && cmd_last_k};
        if (stab_en && prev_hold) begin
            chk("hold_valid", 128'(cmd_valid), 128'd1);
            chk("hold_fields", cur_fields, prev_fields);
        end
        prev_hold   <= cmd_valid && !cmd_ready;
        prev_fields <= cur_fields;
    end

    task automatic tick();
        @(negedge clk);
        if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_job(input int m, input int k, input int nn);
        cfg_m = 12'(m);
        cfg_k = 12'(k);
        cfg_n = 12'(nn);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_m = 12'd1;
        cfg_k = 12'd1;
        cfg_n = 12'd1;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int i;
        i = 0;
        while (!done && i < bound) begin
            tick();
            i++;
        end
        chk(tag, 128'(done), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_m = '0; cfg_k = '0; cfg_n = '0;
        matrix_A_ready = 1'b0; matrix_B_ready = 1'b0; cmd_ready = 1'b0;
        exp2[0] = pk(0, 0, 0, 16, 16, 16, 1'b1, 1'b0);
        exp2[1] = pk(0, 0, 16, 16, 16, 16, 1'b0, 1'b0);
        exp2[2] = pk(0, 0, 32, 16, 16, 8, 1'b0, 1'b1);
        exp2[3] = pk(16, 0, 0, 4, 16, 16, 1'b1, 1'b0);
        exp2[4] = pk(16, 0, 16, 4, 16, 16, 1'b0, 1'b0);
        exp2[5] = pk(16, 0, 32, 4, 16, 8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_error", 128'(error), 128'd0);
        chk("rst_valid", 128'(cmd_valid), 128'd0);
        chk("rst_fields", cur_fields, 128'd0);
        rst = 1'b0;
        tick();

        // Single-tile job
        auto_done = 1'b1; matrix_A_ready = 1'b1; matrix_B_ready = 1'b1; cmd_ready = 1'b1;
        cmdq.delete(); d0 = done_cnt;
        start_job(16, 16, 16);
        chk("t1_busy_after_start", 128'(busy), 128'd1);
        wait_done(40, "t1_done");
        chk("t1_busy_at_done", 128'(busy), 128'd1);
        tick();
        chk("t1_done_width", 128'(done), 128'd0);
        chk("t1_busy_fall", 128'(busy), 128'd0);
        repeat (5) tick();
        chk("t1_done_count", 128'(done_cnt - d0), 128'd1);
        chk("t1_cmd_count", 128'(cmdq.size()), 128'd1);
        chk("t1_cmd0", (cmdq.size() > 0) ? cmdq[0] : 128'd0, pk(0, 0, 0, 16, 16, 16, 1'b1, 1'b1));

        // Stray tile_done while idle is harmless
        man_done = 1'b1; tick(); man_done = 1'b0; tick();
        chk("idle_tile_done_error", 128'(error), 128'd0);

        // 20x40x16 with engine always ready
        cmdq.delete();
        start_job(20, 40, 16);
        wait_done(200, "t2_done");
        tick();
        chk("t2_cmd_count", 128'(cmdq.size()), 128'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_cmd%0d", i), (cmdq.size() > i) ? cmdq[i] : 128'd0, exp2[i]);

        // Same job with random backpressure
        cmdq.delete(); rnd_ready = 1'b1; stab_en = 1'b1;
        start_job(20, 40, 16);
        wait_done(600, "t3_done");
        rnd_ready = 1'b0; stab_en = 1'b0; cmd_ready = 1'b1;
        tick();
        chk("t3_cmd_count", 128'(cmdq.size()), 128'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_cmd%0d", i), (cmdq.size() > i) ? cmdq[i] : 128'd0, exp2[i]);

        // Outstanding limit: 64x16x16 with completions withheld
        auto_done = 1'b0; cmdq.delete();
        start_job(64, 16, 16);
        repeat (20) tick();
        chk("t4_throttle_count", 128'(cmdq.size()), 128'd2);
        chk("t4_throttle_valid", 128'(cmd_valid), 128'd0);
        man_done = 1'b1; tick(); man_done = 1'b0;
        chk("t4_resume_valid", 128'(cmd_valid), 128'd1);
        tick();
        chk("t4_third_cmd", 128'(cmdq.size()), 128'd3);
        for (int p = 0; p < 3; p++) begin
            repeat (4) tick();
            man_done = 1'b1; tick(); man_done = 1'b0;
        end
        wait_done(20, "t4_done");
        chk("t4_cmd_count", 128'(cmdq.size()), 128'd4);
        chk("t4_cmd3", (cmdq.size() > 3) ? cmdq[3] : 128'd0, pk(48, 0, 0, 16, 16, 16, 1'b1, 1'b1));
        tick();

        // Abort on operand loss mid-issue, then recover
        auto_done = 1'b1; cmdq.delete(); d0 = done_cnt;
        start_job(20, 40, 16);
        n = 0;
        while (cmdq.size() < 2 && n < 40) begin tick(); n++; end
        chk("t5_reached_two", 128'(cmdq.size() >= 2), 128'd1);
        matrix_B_ready = 1'b0;
        tick();
        chk("t5_abort_valid", 128'(cmd_valid), 128'd0);
        chk("t5_abort_error", 128'(error), 128'd1);
        chk("t5_abort_busy", 128'(busy), 128'd0);
        repeat (10) tick();
        chk("t5_no_done", 128'(done_cnt - d0), 128'd0);
        chk("t5_error_sticky", 128'(error), 128'd1);
        matrix_B_ready = 1'b1;
        start_job(16, 16, 16);
        chk("t5_error_cleared", 128'(error), 128'd0);
        wait_done(40, "t5_recover_done");
        chk("t5_recover_error", 128'(error), 128'd0);
        tick();

        // Zero dimension
        cmdq.delete();
        start_job(16, 0, 16);
        chk("t6_error", 128'(error), 128'd1);
        chk("t6_busy", 128'(busy), 128'd0);
        repeat (5) tick();
        chk("t6_no_cmd", 128'(cmdq.size()), 128'd0);
        chk("t6_valid", 128'(cmd_valid), 128'd0);

        // Asynchronous reset mid-job
        start_job(64, 16, 16);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_valid", 128'(cmd_valid), 128'd0);
        chk("arst_error", 128'(error), 128'd0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
